// File: rtl/sa_sequencer_pkg.sv
// Shared definitions for the systolic-array sequencer: FSM states and lane slicing.
package sa_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Reset-to-zero shift register of DEPTH stages used for row skew and top-valid alignment.
module sa_skew_line
   import sa_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= d;
               for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/sa_sequencer.sv
// Sequencer for one ROWS x COLS output-accumulating PE array: weight load, skewed
// activation streaming, top-edge valids, bottom-edge result counting and done.
module sa_sequencer
   import sa_sequencer_pkg::*;
#(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 4,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned ACCU_DATA_WIDTH = 2 * DATA_WIDTH,
   parameter int unsigned LEN_W           = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            load_en,
   input  logic [LEN_W-1:0]                k_len,
   output logic                            busy,
   output logic                            done,
   input  logic [ROWS*DATA_WIDTH-1:0]      w_data,
   input  logic                            w_valid,
   output logic                            w_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]      a_data,
   input  logic                            a_valid,
   output logic                            a_ready,
   output logic [ROWS*DATA_WIDTH-1:0]      arr_data_left,
   output logic [ROWS-1:0]                 arr_valid_left,
   output logic [ROWS-1:0]                 arr_cmd,
   output logic [COLS*ACCU_DATA_WIDTH-1:0] arr_data_top,
   output logic [COLS-1:0]                 arr_valid_top,
   input  logic [COLS-1:0]                 arr_valid_down
);

   state_t                    state;
   logic [LEN_W-1:0]          k_reg;
   logic [LEN_W-1:0]          beat_cnt;
   logic [LEN_W-1:0]          col_cnt [COLS];
   logic                      w_fire, a_fire;
   logic [ROWS*DATA_WIDTH-1:0] edge_data;
   logic                      edge_valid, edge_cmd;
   logic                      stream_valid0;

   assign w_fire = w_valid & w_ready;
   assign a_fire = a_valid & a_ready;

   // done is registered alongside the state; a k_len==0 job spends one extra
   // DONE cycle with done low so the pulse lands two cycles after start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         k_reg    <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         w_ready  <= 1'b0;
         a_ready  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  k_reg    <= k_len;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  if (k_len == '0) begin
                     state <= ST_DONE;
                  end else if (load_en) begin
                     state   <= ST_LOAD;
                     w_ready <= 1'b1;
                  end else begin
                     state   <= ST_STREAM;
                     a_ready <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (w_fire) begin
                  if (beat_cnt == LEN_W'(COLS - 1)) begin
                     state    <= ST_STREAM;
                     beat_cnt <= '0;
                     w_ready  <= 1'b0;
                     a_ready  <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_W'(1);
                  end
               end
            end
            ST_STREAM: begin
               if (a_fire) begin
                  if (beat_cnt == k_reg - LEN_W'(1)) begin
                     state   <= ST_DRAIN;
                     a_ready <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (arr_valid_down[COLS-1] && (col_cnt[COLS-1] == k_reg - LEN_W'(1))) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (done) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < COLS; c++) col_cnt[c] <= '0;
      end else if (state == ST_IDLE && start) begin
         for (int unsigned c = 0; c < COLS; c++) col_cnt[c] <= '0;
      end else if (state == ST_STREAM || state == ST_DRAIN) begin
         for (int unsigned c = 0; c < COLS; c++)
            if (arr_valid_down[c]) col_cnt[c] <= col_cnt[c] + LEN_W'(1);
      end
   end

   // Common output stage; bubbles are forced to all-zero lanes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_data  <= '0;
         edge_valid <= 1'b0;
         edge_cmd   <= 1'b0;
      end else begin
         edge_valid <= w_fire | a_fire;
         edge_cmd   <= w_fire;
         edge_data  <= w_fire ? w_data : (a_fire ? a_data : '0);
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH+1:0] lane_in, lane_out;

      assign lane_in = {edge_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH], edge_valid, edge_cmd};

      if (r == 0) begin : g_direct
         assign lane_out = lane_in;
      end else begin : g_skew
         sa_skew_line #(.WIDTH(DATA_WIDTH + 2), .DEPTH(r)) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (lane_in),
            .q     (lane_out)
         );
      end

      assign arr_data_left[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = lane_out[DATA_WIDTH+1:2];
      assign arr_valid_left[r] = lane_out[1];
      assign arr_cmd[r]        = lane_out[0];
   end

   assign stream_valid0 = edge_valid & ~edge_cmd;

   for (genvar c = 0; c < COLS; c++) begin : g_top
      sa_skew_line #(.WIDTH(1), .DEPTH(c + 1)) u_top (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (stream_valid0),
         .q     (arr_valid_top[c])
      );
   end

   assign arr_data_top = '0;

endmodule
